icache_responder: RTL and testbench
===================================

ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 SHALL have port clk_i  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port rstn_i  in  1  asynchronous active-low reset.
REQ-003 SHALL have port req_valid_i  in  1  fetch request valid.
REQ-004 SHALL have port req_vaddr_i  in  40  fetch virtual address (addr_t).
REQ-005 SHALL have port flush_i  in  1  invalidate line buffer, cancel outstanding miss.
REQ-006 SHALL have port resp_valid_o  out  1  response valid to fetch.
REQ-007 SHALL have port resp_data_o  out  32  instruction word.
REQ-008 SHALL have port resp_xcpt_o  out  1  fetch exception (misaligned or bus error).
REQ-009 SHALL have port mem_req_valid_o  out  1  line refill request valid.
REQ-010 SHALL have port mem_req_ready_i  in  1  memory accepts refill request.
REQ-011 SHALL have port mem_req_addr_o  out  40  line-aligned refill address, bits [3:0]=0.
REQ-012 SHALL have port mem_resp_valid_i  in  1  refill data valid, one cycle.
REQ-013 SHALL have port mem_resp_data_i  in  128  refill line, word n at bits [32n+31:32n].
REQ-014 SHALL have port mem_resp_error_i  in  1  refill bus error, qualified by mem_resp_valid_i.

Function
REQ-015 SHALL hold one 128-bit line buffer, 36-bit tag (vaddr[39:4]) and a line-valid bit.
REQ-016 SHALL implement FSM states IDLE, MISS_REQ, MISS_WAIT; reset state IDLE.
REQ-017 IDLE, req_valid_i=1, vaddr[1:0]!=0: next cycle resp_valid_o=1, resp_xcpt_o=1, resp_data_o=0; no memory access.
REQ-018 IDLE, req_valid_i=1, aligned, line valid and tag match (hit): next cycle resp_valid_o=1, resp_xcpt_o=0, resp_data_o=line word vaddr[3:2].
REQ-019 IDLE, aligned miss: latch vaddr, go MISS_REQ; no response issued.
REQ-020 MISS_REQ: mem_req_valid_o=1, mem_req_addr_o={latched vaddr[39:4],4'h0}, held stable until mem_req_ready_i=1; then go MISS_WAIT.
REQ-021 MISS_WAIT, mem_resp_valid_i=1, error=0: fill buffer, set tag, line-valid=1; next cycle resp_valid_o=1 with word latched vaddr[3:2]; go IDLE.
REQ-022 MISS_WAIT, mem_resp_valid_i=1, error=1: no fill, line-valid=0; next cycle resp_valid_o=1, resp_xcpt_o=1, resp_data_o=0; go IDLE.
REQ-023 Response outputs SHALL be registered, pulse exactly one cycle per accepted request; no response while not in IDLE except REQ-021/022.
REQ-024 Hit latency 1 cycle; miss latency = 1 + request-handshake cycles + memory latency + 1.
REQ-025 flush_i=1 SHALL clear line-valid that cycle and suppress any response due the next cycle; IDLE requests that same cycle ignored.
REQ-026 flush_i in MISS_REQ: if ready not yet seen, drop request (mem_req_valid_o low next cycle), go IDLE; if ready same cycle, go MISS_WAIT with drop flag.
REQ-027 flush_i in MISS_WAIT: set drop flag; on mem_resp_valid_i discard data, no fill, no response, go IDLE.
REQ-028 mem_resp_valid_i outside MISS_WAIT SHALL be ignored.
REQ-029 req_valid_i and req_vaddr_i SHALL be ignored outside IDLE.

Reset
REQ-030 Reset SHALL force IDLE, line-valid=0, drop flag=0, tag/buffer=0, resp_valid_o=0, resp_xcpt_o=0, resp_data_o=0, mem_req_valid_o=0, mem_req_addr_o=0.
REQ-031 Reset mid-miss SHALL abandon the miss; a later mem_resp_valid_i SHALL not fill or respond.

Verification
REQ-032 Cold miss: req 0x100, ready=1 immediately, resp 3 cycles later with line 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> mem_req_addr_o=0x100, resp_data_o=0xAAAAAAAA, xcpt=0.
REQ-033 Hit: then req 0x108 -> next cycle resp_data_o=0xCCCCCCCC, no mem_req_valid_o.
REQ-034 Backpressure: miss 0x200, ready low 4 cycles -> mem_req_valid_o high and addr 0x200 stable all 5 cycles.
REQ-035 Error: miss 0x300, mem_resp_error_i=1 -> resp_xcpt_o=1, resp_data_o=0; re-request 0x300 misses again.
REQ-036 Flush in MISS_WAIT: miss 0x400, flush_i, resp arrives -> no resp_valid_o, line-valid=0; req 0x400 misses.
REQ-037 Misaligned: req 0x102 -> next cycle resp_xcpt_o=1, mem_req_valid_o never asserted.

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signal bundle for the single-line instruction cache responder.
interface icache_responder_if;
  logic         req_valid_i;
  logic [39:0]  req_vaddr_i;
  logic         flush_i;
  logic         resp_valid_o;
  logic [31:0]  resp_data_o;
  logic         resp_xcpt_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [39:0]  mem_req_addr_o;
  logic         mem_resp_valid_i;
  logic [127:0] mem_resp_data_i;
  logic         mem_resp_error_i;

  // The responder itself.
  modport slave (
    input  req_valid_i, req_vaddr_i, flush_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_error_i,
    output resp_valid_o, resp_data_o, resp_xcpt_o,
    output mem_req_valid_o, mem_req_addr_o
  );

  // Fetch unit plus memory model driving the responder.
  modport master (
    output req_valid_i, req_vaddr_i, flush_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_error_i,
    input  resp_valid_o, resp_data_o, resp_xcpt_o,
    input  mem_req_valid_o, mem_req_addr_o
  );
endinterface

// File: rtl/icache_responder.sv
// Single-line instruction cache responder: one 128-bit line buffer, hit in one
// cycle, otherwise a line refill over a valid/ready request and a one-cycle
// response. A flush invalidates the line and cancels any miss in flight.
module icache_responder (
  input logic            clk_i,
  input logic            rstn_i,
  icache_responder_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MISS_REQ  = 2'd1;
  localparam logic [1:0] MISS_WAIT = 2'd2;

  logic [1:0]   state;
  logic [127:0] line_buf;
  logic [35:0]  tag;
  logic         line_valid;
  logic         drop;
  logic [39:0]  miss_addr;

  logic         resp_valid;
  logic         resp_xcpt;
  logic [31:0]  resp_data;

  logic         misaligned;
  logic         hit;
  logic [31:0]  hit_word;
  logic [31:0]  fill_word;

  // Word n of a line lives at bits [32n+31:32n].
  function automatic logic [31:0] select_word(input logic [127:0] line, input logic [1:0] idx);
    return line[{idx, 5'b0} +: 32];
  endfunction

  assign misaligned = (bus.req_vaddr_i[1:0] != 2'b00);
  assign hit        = line_valid && (tag == bus.req_vaddr_i[39:4]);
  assign hit_word   = select_word(line_buf, bus.req_vaddr_i[3:2]);
  assign fill_word  = select_word(bus.mem_resp_data_i, miss_addr[3:2]);

  // The refill request is a pure function of state, so a dropped request
  // disappears the cycle after the FSM leaves MISS_REQ.
  assign bus.mem_req_valid_o = (state == MISS_REQ);
  assign bus.mem_req_addr_o  = {miss_addr[39:4], 4'h0};

  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_xcpt_o  = resp_xcpt;
  assign bus.resp_data_o  = resp_data;

  // FSM, line buffer and one-cycle response pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      line_buf   <= '0;
      tag        <= '0;
      line_valid <= 1'b0;
      drop       <= 1'b0;
      miss_addr  <= '0;
      resp_valid <= 1'b0;
      resp_xcpt  <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_xcpt  <= 1'b0;
      resp_data  <= '0;
      if (bus.flush_i) line_valid <= 1'b0;

      case (state)
        IDLE: begin
          // A flush in the same cycle swallows the request entirely.
          if (bus.req_valid_i && !bus.flush_i) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_xcpt  <= 1'b1;
            end else if (hit) begin
              resp_valid <= 1'b1;
              resp_data  <= hit_word;
            end else begin
              miss_addr <= bus.req_vaddr_i;
              state     <= MISS_REQ;
            end
          end
        end

        MISS_REQ: begin
          // Once the handshake completes the memory owes us a response, so a
          // flush here can only mark it for discard.
          if (bus.mem_req_ready_i) begin
            state <= MISS_WAIT;
            drop  <= bus.flush_i;
          end else if (bus.flush_i) begin
            state <= IDLE;
          end
        end

        MISS_WAIT: begin
          if (bus.flush_i) drop <= 1'b1;
          if (bus.mem_resp_valid_i) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (!(drop || bus.flush_i)) begin
              resp_valid <= 1'b1;
              if (bus.mem_resp_error_i) begin
                line_valid <= 1'b0;
                resp_xcpt  <= 1'b1;
              end else begin
                line_buf   <= bus.mem_resp_data_i;
                tag        <= miss_addr[39:4];
                line_valid <= 1'b1;
                resp_data  <= fill_word;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, hit, backpressure, bus error,
// flushes in each state, misaligned fetch and reset in the middle of a miss.
module tb_icache_responder;

  logic clk;
  logic rstn;
  int   n_asserts;
  int   n_fail;

  icache_responder_if bus ();

  icache_responder dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid_i      = 1'b0;
    bus.req_vaddr_i      = '0;
    bus.flush_i          = 1'b0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i  = '0;
    bus.mem_resp_error_i = 1'b0;
  endtask

  task automatic request(input logic [39:0] addr);
    bus.req_valid_i = 1'b1;
    bus.req_vaddr_i = addr;
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic mem_respond(input logic [127:0] line, input logic err);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_data_i  = line;
    bus.mem_resp_error_i = err;
    tick();
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i  = '0;
    bus.mem_resp_error_i = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_resp_xcpt", bus.resp_xcpt_o, 0);
    chk("rst_resp_data", bus.resp_data_o, 0);
    chk("rst_mem_valid", bus.mem_req_valid_o, 0);
    chk("rst_mem_addr", bus.mem_req_addr_o, 0);
    rstn = 1'b1;
    tick();

    // Cold miss 0x100, ready immediately, response three cycles later
    request(40'h100);
    chk("cold_mem_valid", bus.mem_req_valid_o, 1);
    chk("cold_mem_addr", bus.mem_req_addr_o, 40'h100);
    chk("cold_no_resp", bus.resp_valid_o, 0);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    chk("cold_req_dropped", bus.mem_req_valid_o, 0);
    tick();
    tick();
    chk("cold_wait_no_resp", bus.resp_valid_o, 0);
    mem_respond(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0);
    chk("cold_resp_valid", bus.resp_valid_o, 1);
    chk("cold_resp_data", bus.resp_data_o, 32'hAAAAAAAA);
    chk("cold_resp_xcpt", bus.resp_xcpt_o, 0);
    tick();
    chk("cold_resp_pulse", bus.resp_valid_o, 0);

    // Hits on the filled line
    request(40'h108);
    chk("hit108_valid", bus.resp_valid_o, 1);
    chk("hit108_data", bus.resp_data_o, 32'hCCCCCCCC);
    chk("hit108_no_mem", bus.mem_req_valid_o, 0);
    request(40'h10C);
    chk("hit10c_data", bus.resp_data_o, 32'hDDDDDDDD);
    chk("hit10c_xcpt", bus.resp_xcpt_o, 0);

    // Backpressure: miss 0x204, ready low for four cycles
    request(40'h204);
    for (int i = 0; i < 4; i++) begin
      chk("bp_mem_valid", bus.mem_req_valid_o, 1);
      chk("bp_mem_addr", bus.mem_req_addr_o, 40'h200);
      tick();
    end
    chk("bp_mem_valid5", bus.mem_req_valid_o, 1);
    chk("bp_mem_addr5", bus.mem_req_addr_o, 40'h200);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    chk("bp_req_done", bus.mem_req_valid_o, 0);
    mem_respond(128'h44444444_33333333_22222222_11111111, 1'b0);
    chk("bp_resp_valid", bus.resp_valid_o, 1);
    chk("bp_resp_data", bus.resp_data_o, 32'h22222222);

    // Bus error on miss 0x300
    request(40'h300);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    mem_respond(128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b1);
    chk("err_resp_valid", bus.resp_valid_o, 1);
    chk("err_resp_xcpt", bus.resp_xcpt_o, 1);
    chk("err_resp_data", bus.resp_data_o, 0);
    request(40'h300);
    chk("err_rerequest_miss", bus.mem_req_valid_o, 1);
    chk("err_rerequest_no_resp", bus.resp_valid_o, 0);

    // Flush in MISS_REQ before ready: request withdrawn
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("flushreq_mem_valid", bus.mem_req_valid_o, 0);
    chk("flushreq_no_resp", bus.resp_valid_o, 0);

    // Flush in MISS_WAIT: response discarded, line stays invalid
    request(40'h400);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    mem_respond(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b0);
    chk("flushwait_no_resp", bus.resp_valid_o, 0);
    request(40'h400);
    chk("flushwait_misses", bus.mem_req_valid_o, 1);
    chk("flushwait_miss_addr", bus.mem_req_addr_o, 40'h400);
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    mem_respond(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b0);
    chk("refill400_data", bus.resp_data_o, 32'h0A0A0A0A);

    // Flush in IDLE alongside a would-be hit: request ignored, line invalidated
    bus.flush_i = 1'b1;
    request(40'h404);
    bus.flush_i = 1'b0;
    chk("flushidle_no_resp", bus.resp_valid_o, 0);
    chk("flushidle_no_mem", bus.mem_req_valid_o, 0);
    request(40'h404);
    chk("flushidle_then_miss", bus.mem_req_valid_o, 1);
    chk("flushidle_then_no_resp", bus.resp_valid_o, 0);

    // Reset in the middle of the miss, then a stray memory response
    rstn = 1'b0;
    #1;
    chk("midrst_mem_valid", bus.mem_req_valid_o, 0);
    chk("midrst_mem_addr", bus.mem_req_addr_o, 0);
    #1;
    rstn = 1'b1;
    tick();
    mem_respond(128'hFFFFFFFF_EEEEEEEE_99999999_88888888, 1'b0);
    chk("midrst_stray_no_resp", bus.resp_valid_o, 0);
    request(40'h400);
    chk("midrst_line_invalid", bus.mem_req_valid_o, 1);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;

    // Misaligned fetch
    request(40'h102);
    chk("mis_resp_valid", bus.resp_valid_o, 1);
    chk("mis_resp_xcpt", bus.resp_xcpt_o, 1);
    chk("mis_resp_data", bus.resp_data_o, 0);
    chk("mis_no_mem", bus.mem_req_valid_o, 0);
    tick();
    chk("mis_no_mem_later", bus.mem_req_valid_o, 0);
    chk("mis_resp_pulse", bus.resp_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
